// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb3.sv
// Purpose: three-requester round-robin arbiter with bounded hold time and a one-cycle gap between grants.
// Latency: one edge from sampled request to grant (from IDLE or GAP); every output is registered.
// Backpressure: level-sensitive requests, nothing is latched; the holder is revoked after MAXHOLD cycles.
//
// Ports:
//   CLK              clock, all state changes on the rising edge
//   RN               synchronous active-low reset, dominates all other inputs
//   REQ1..REQ3       request lines, held high while access is wanted
//   GNT1..GNT3       registered one-hot grants (at most one high)
//   BUSY             registered, high exactly when any grant is high
//   TMO              registered one-cycle pulse when the hold limit revokes a grant
//   VDD, VSS         power pins, only with USE_POWER_PINS
//
// MAXHOLD must lie in 1..2^CW-1 so the hold counter never wraps.
module gf180mcu_fd_sc_mcu9t5v0__rrarb3 #(
    parameter int CW      = 8,
    parameter int MAXHOLD = 8
) (
`ifdef USE_POWER_PINS
    inout  wire  VDD,
    inout  wire  VSS,
`endif
    input  logic CLK,
    input  logic RN,
    input  logic REQ1,
    input  logic REQ2,
    input  logic REQ3,
    output logic GNT1,
    output logic GNT2,
    output logic GNT3,
    output logic BUSY,
    output logic TMO
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAXHOLD);

    logic [1:0]    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;      // last granted requester, 1..3
    logic [CW-1:0] cnt_q, cnt_d;      // cycles spent in the current tenure
    logic [2:0]    gnt_q, gnt_d;      // bit 0 = requester 1
    logic          busy_q;
    logic          tmo_q, tmo_d;
    logic [2:0]    req;
    logic [1:0]    pick;              // 0 = nobody requesting
    logic          hold;              // current holder still requesting

    assign req  = {REQ3, REQ2, REQ1};
    assign hold = |(gnt_q & req);

    // Cyclic scan starting just after the last winner, so the previous
    // holder always ends up with the lowest priority.
    always_comb begin
        pick = 2'd0;
        case (ptr_q)
            2'd1: begin
                if (req[1])      pick = 2'd2;
                else if (req[2]) pick = 2'd3;
                else if (req[0]) pick = 2'd1;
            end
            2'd2: begin
                if (req[2])      pick = 2'd3;
                else if (req[0]) pick = 2'd1;
                else if (req[1]) pick = 2'd2;
            end
            default: begin
                if (req[0])      pick = 2'd1;
                else if (req[1]) pick = 2'd2;
                else if (req[2]) pick = 2'd3;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            S_GRANT: begin
                if (!hold) begin
                    // Release wins over a coincident timeout: no TMO.
                    gnt_d   = 3'b000;
                    state_d = S_GAP;
                end else if (cnt_q == CNT_MAX) begin
                    gnt_d   = 3'b000;
                    tmo_d   = 1'b1;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // IDLE and GAP arbitrate identically; the gap is simply the
                // one all-zero cycle forced after every grant.
                if (pick != 2'd0) begin
                    state_d = S_GRANT;
                    ptr_d   = pick;
                    cnt_d   = CW'(1);
                    gnt_d   = {pick == 2'd3, pick == 2'd2, pick == 2'd1};
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = 3'b000;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
            gnt_q   <= 3'b000;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            busy_q  <= |gnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign GNT1 = gnt_q[0];
    assign GNT2 = gnt_q[1];
    assign GNT3 = gnt_q[2];
    assign BUSY = busy_q;
    assign TMO  = tmo_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rrarb3.sv
// Purpose: self-checking bench for the three-way round-robin arbiter, four hold limits in parallel.
// Latency: outputs sampled 1 time unit after each rising edge against a tenure-level reference model.
// Backpressure: none; requests are driven directly, random phase toggles them and pulses reset.
module tb_gf180mcu_fd_sc_mcu9t5v0__rrarb3;

    logic       CLK = 1'b0;
    logic       RN  = 1'b0;
    logic [2:0] req = 3'b000;   // bit 0 = REQ1

    // {TMO, BUSY, GNT3, GNT2, GNT1} per instance
    logic [4:0] o_a, o_b, o_c, o_d;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu9t5v0__rrarb3 #(.CW(4), .MAXHOLD(2)) dut_a (
        .CLK(CLK), .RN(RN), .REQ1(req[0]), .REQ2(req[1]), .REQ3(req[2]),
        .GNT1(o_a[0]), .GNT2(o_a[1]), .GNT3(o_a[2]), .BUSY(o_a[3]), .TMO(o_a[4]));
    // CW=2 with MAXHOLD=3 sits at the top of the legal range.
    gf180mcu_fd_sc_mcu9t5v0__rrarb3 #(.CW(2), .MAXHOLD(3)) dut_b (
        .CLK(CLK), .RN(RN), .REQ1(req[0]), .REQ2(req[1]), .REQ3(req[2]),
        .GNT1(o_b[0]), .GNT2(o_b[1]), .GNT3(o_b[2]), .BUSY(o_b[3]), .TMO(o_b[4]));
    gf180mcu_fd_sc_mcu9t5v0__rrarb3 #(.CW(8), .MAXHOLD(4)) dut_c (
        .CLK(CLK), .RN(RN), .REQ1(req[0]), .REQ2(req[1]), .REQ3(req[2]),
        .GNT1(o_c[0]), .GNT2(o_c[1]), .GNT3(o_c[2]), .BUSY(o_c[3]), .TMO(o_c[4]));
    gf180mcu_fd_sc_mcu9t5v0__rrarb3 #(.CW(8), .MAXHOLD(8)) dut_d (
        .CLK(CLK), .RN(RN), .REQ1(req[0]), .REQ2(req[1]), .REQ3(req[2]),
        .GNT1(o_d[0]), .GNT2(o_d[1]), .GNT3(o_d[2]), .BUSY(o_d[3]), .TMO(o_d[4]));

    int maxh[4] = '{2, 3, 4, 8};

    // Reference model: who holds the resource (0 = nobody), how long the
    // tenure has lasted, who was last served, and the timeout pulse.
    int m_owner[4] = '{0, 0, 0, 0};
    int m_held[4]  = '{0, 0, 0, 0};
    int m_last[4]  = '{3, 3, 3, 3};
    bit m_tmo[4]   = '{0, 0, 0, 0};

    int nassert = 0;
    int nfail   = 0;

    function automatic logic [4:0] obs(int i);
        case (i)
            0:       return o_a;
            1:       return o_b;
            2:       return o_c;
            default: return o_d;
        endcase
    endfunction

    function automatic logic [4:0] expv(int i);
        return {m_tmo[i], m_owner[i] != 0, m_owner[i] == 3, m_owner[i] == 2, m_owner[i] == 1};
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 4; i++) begin
            if (!RN) begin
                m_owner[i] = 0;
                m_held[i]  = 0;
                m_last[i]  = 3;
                m_tmo[i]   = 1'b0;
            end else if (m_owner[i] != 0) begin
                m_tmo[i] = 1'b0;
                if (!req[m_owner[i]-1]) begin
                    m_owner[i] = 0;
                end else if (m_held[i] == maxh[i]) begin
                    m_owner[i] = 0;
                    m_tmo[i]   = 1'b1;
                end else begin
                    m_held[i] = m_held[i] + 1;
                end
            end else begin
                int win;
                m_tmo[i] = 1'b0;
                win = 0;
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (m_last[i] + k - 1) % 3 + 1;
                    if (win == 0 && req[c-1]) win = c;
                end
                if (win != 0) begin
                    m_owner[i] = win;
                    m_last[i]  = win;
                    m_held[i]  = 1;
                end
            end
        end
    endtask

    task automatic check(string tag, int i, logic [4:0] want);
        nassert++;
        assert (obs(i) === want) else begin
            nfail++;
            $error("FAIL %s dut%0d observed=%b expected=%b", tag, i, obs(i), want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        for (int i = 0; i < 4; i++) check("model", i, expv(i));
    endtask

    initial begin
        logic [4:0] w;

        // Reset held two edges with every request high.
        RN = 1'b0; req = 3'b111;
        tick(); tick();
        for (int i = 0; i < 4; i++) check("reset", i, 5'b00000);

        // Release: requester 1 wins first on every instance.
        RN = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) check("first_gnt", i, 5'b01001);

        // Fairness on MAXHOLD=4 with all requests held.
        for (int t = 1; t <= 15; t++) begin
            int p, own;
            tick();
            p   = t % 5;
            own = (p < 4) ? (t / 5) % 3 + 1 : 0;
            w   = {p == 4, own != 0, own == 3, own == 2, own == 1};
            check("fair", 2, w);
        end

        // Early release on MAXHOLD=8.
        RN = 1'b0; req = 3'b000; tick();
        RN = 1'b1; req = 3'b010;
        tick(); check("early_g1", 3, 5'b01010);
        tick(); check("early_g2", 3, 5'b01010);
        req = 3'b000;
        tick(); check("early_gap", 3, 5'b00000);
        tick(); check("early_idle", 3, 5'b00000);

        // Lone requester on MAXHOLD=3.
        RN = 1'b0; tick();
        RN = 1'b1; req = 3'b100;
        for (int t = 0; t < 12; t++) begin
            tick();
            w = (t % 4 < 3) ? 5'b01100 : 5'b10000;
            check("lone", 1, w);
        end

        // Release coinciding with the hold limit on MAXHOLD=2.
        RN = 1'b0; req = 3'b000; tick();
        RN = 1'b1; req = 3'b001;
        tick(); check("coin_g1", 0, 5'b01001);
        tick(); check("coin_g2", 0, 5'b01001);
        req = 3'b010;
        tick(); check("coin_gap", 0, 5'b00000);
        tick(); check("coin_next", 0, 5'b01010);

        // Reset during the second cycle of a GNT2 tenure.
        RN = 1'b0; req = 3'b000; tick();
        RN = 1'b1; req = 3'b010;
        tick(); tick();
        RN = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) check("mid_rst", i, 5'b00000);
        RN = 1'b1; req = 3'b111;
        tick();
        for (int i = 0; i < 4; i++) check("post_rst", i, 5'b01001);

        // Random requests with sticky levels and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            RN = ($urandom_range(0, 63) != 0);
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
